// File: rtl/ark_key_sched.sv
// ark_key_sched: byte-serial AddRoundKey stage with an in-place AES-128 key
// schedule. Key bytes stream in once; every 16 data bytes the round key is
// advanced by one expansion step, and after round NR the original cipher key
// is restored so the next block starts again at round 0.
module ark_key_sched #(
    parameter int NB = 16,
    parameter int NR = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_load,
    input  logic [7:0] key_in,
    input  logic       data_valid,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    output logic       key_ready,
    output logic [3:0] round,
    output logic       last_round,
    output logic       err
);

    typedef enum logic [2:0] {IDLE, LOAD, READY, EXPAND, RESTORE} state_t;

    localparam logic [3:0] LAST_BYTE  = 4'(NB - 1);
    localparam logic [3:0] LAST_ROUND = 4'(NR);

    state_t       state;
    state_t       state_next;
    logic [7:0]   kr [16];
    logic [7:0]   ks [16];
    logic [3:0]   bc;
    logic [7:0]   sub_out [4];
    logic [31:0]  t_word;
    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  n0, n1, n2, n3;
    logic [127:0] next_key;

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires)
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = a;
        for (int i = 0; i < 7; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    // Forward S-box: field inverse followed by the affine transform
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] v;
        v = gf_inv(a);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
                 ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    // Round constant for the key of round r+1
    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Four parallel forward S-boxes on RotWord(w3)
    for (genvar i = 0; i < 4; i++) begin : g_sub_bytes
        assign sub_out[i] = sbox(kr[12 + ((i + 1) % 4)]);
    end

    // Next round key, all four words computed in one cycle
    always_comb begin
        w0       = {kr[0],  kr[1],  kr[2],  kr[3]};
        w1       = {kr[4],  kr[5],  kr[6],  kr[7]};
        w2       = {kr[8],  kr[9],  kr[10], kr[11]};
        w3       = {kr[12], kr[13], kr[14], kr[15]};
        t_word   = {sub_out[0] ^ rcon(round), sub_out[1], sub_out[2], sub_out[3]};
        n0       = w0 ^ t_word;
        n1       = w1 ^ n0;
        n2       = w2 ^ n1;
        n3       = w3 ^ n2;
        next_key = {n0, n1, n2, n3};
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic; a key load outside LOAD always restarts the load
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (key_load) state_next = LOAD;
            LOAD:    if (key_load && bc == LAST_BYTE) state_next = READY;
            READY: begin
                if (key_load)
                    state_next = LOAD;
                else if (data_valid && bc == LAST_BYTE)
                    state_next = (round == LAST_ROUND) ? RESTORE : EXPAND;
            end
            EXPAND,
            RESTORE: state_next = key_load ? LOAD : READY;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs decoded from state and round
    always_comb begin
        key_ready  = (state == READY);
        last_round = (round == LAST_ROUND);
    end

    // Key storage, counters, data path and sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                kr[i] <= 8'h00;
                ks[i] <= 8'h00;
            end
            bc             <= 4'd0;
            round          <= 4'd0;
            data_out       <= 8'h00;
            data_out_valid <= 1'b0;
            err            <= 1'b0;
        end else begin
            data_out_valid <= 1'b0;
            if (key_load) begin
                err <= 1'b0;
                if (state == LOAD) begin
                    kr[bc] <= key_in;
                    ks[bc] <= key_in;
                    bc     <= bc + 4'd1;
                end else begin
                    kr[0] <= key_in;
                    ks[0] <= key_in;
                    bc    <= 4'd1;
                    round <= 4'd0;
                end
            end else begin
                if (data_valid && state != READY) err <= 1'b1;
                case (state)
                    READY: begin
                        if (data_valid) begin
                            data_out       <= data_in ^ kr[bc];
                            data_out_valid <= 1'b1;
                            bc             <= bc + 4'd1;
                        end
                    end
                    EXPAND: begin
                        for (int i = 0; i < 16; i++) kr[i] <= next_key[127 - 8 * i -: 8];
                        round <= round + 4'd1;
                    end
                    RESTORE: begin
                        for (int i = 0; i < 16; i++) kr[i] <= ks[i];
                        round <= 4'd0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/ark_key_sched.md
Name: ark_key_sched

Overview:
- Byte-serial AddRoundKey stage with an integrated AES-128 key schedule.
- Sits directly downstream of the byte-serial encrypt round datapath (SubBytes/ShiftRows/MixColumns, serialised through pts_converter).
- XORs each state byte with the matching round-key byte and advances the round key in place after every 16 bytes.
- Also performs the initial (round 0) key addition on plaintext bytes.

Parameters:
- NB, 16, bytes per state/key block (fixed for AES-128)
- NR, 10, number of rounds; round keys 0..NR are produced

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- key_load  in  1  key_in byte valid this cycle (cipher key load)
- key_in  in  8  cipher key byte, byte 0 first (FIPS-197 column-major order)
- data_valid  in  1  data_in byte valid this cycle
- data_in  in  8  state byte, byte 0 first
- data_out  out  8  data_in XOR round-key byte, registered
- data_out_valid  out  1  data_out valid
- key_ready  out  1  block accepts data_valid this cycle
- round  out  4  index of the round key currently applied (0..10)
- last_round  out  1  high while round==NR
- err  out  1  sticky: data_valid seen while key_ready low; cleared by rst or key_load

Behaviour:
- Reset (rst=1 at clk edge) values:
  - data_out=0, data_out_valid=0, key_ready=0, round=0, last_round=0, err=0
  - byte counter=0, state=IDLE; key and saved-key registers cleared
- State registers:
  - kr[0..15]: current round key
  - ks[0..15]: saved cipher key
  - 4-bit byte counter bc
  - 4-bit round counter
- States: IDLE, LOAD, READY, EXPAND, RESTORE.
- IDLE:
  - key_ready=0.
  - key_load -> LOAD; the first byte is captured into kr[0]/ks[0] and bc=1.
- LOAD:
  - Each key_load cycle writes key_in to kr[bc] and ks[bc], then bc++.
  - Cycles without key_load stall; bc holds.
  - Capture of byte 15 -> READY, bc=0, round=0, key_ready=1 from the next cycle.
- READY:
  - Each data_valid cycle: data_out <= data_in ^ kr[bc], data_out_valid <= 1, bc++ (latency 1 cycle).
  - data_out_valid is a 1-cycle pulse per accepted byte; data_out holds its value otherwise.
  - When byte bc=15 is accepted, bc wraps to 0:
    - round<NR -> EXPAND
    - round==NR -> RESTORE
  - key_ready deasserts combinationally in EXPAND and RESTORE.
- EXPAND (exactly 1 cycle): compute the next round key in parallel.
  - t = SubWord(RotWord(w3)) ^ {rcon,00,00,00}, using 4 sub_bytes instances with mode=0.
  - w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
  - Word wi = kr[4i..4i+3], with kr[4i] as the most-significant byte.
  - rcon indexed by the new round: 01,02,04,08,10,20,40,80,1B,36.
  - round++, -> READY.
- RESTORE (exactly 1 cycle): kr <= ks, round=0, -> READY, so the next block reuses the same cipher key.
- last_round = (round==NR).
- data_valid while key_ready=0:
  - The byte is ignored: no output, no bc change.
  - err is set.
- key_load in any state other than LOAD:
  - Aborts the current operation; bc, round, and err are cleared.
  - key_in is captured as byte 0; -> LOAD.
  - A block in flight is discarded.
- key_load and data_valid in the same cycle: key_load wins; data is ignored and err is not set.
- rst mid-load or mid-block returns to IDLE with all reset values; a full 16-byte key reload is required.
- Throughput: one block = 11 rounds x 16 bytes + 10 EXPAND cycles + 1 RESTORE cycle.

Test Plan:
- Key 2b7e151628aed2a6abf7158809cf4f3c, then plaintext 3243f6a8885a308d313198a2e0370734 at round 0 -> data_out stream 193de3bea0f4e22b9ac68d2ae9f84808, one byte per cycle, 1-cycle latency; key_ready low for exactly 1 cycle afterwards; round=1.
- Same key, 16 bytes of zero data per round for 11 rounds -> round-1 output a0fafe1788542cb123a339392a6c7605, round-10 output d014f9a8c9ee2589e13f0cc8b6630ca6; last_round high only during round 10; RESTORE cycle follows, then round=0 with the round-0 key returned.
- Key all zeros, zero data, rounds 0 and 1 -> round-0 output all 00; round-1 output 62636363626363636263636362636363.
- data_valid asserted in the EXPAND cycle -> byte dropped, no data_out_valid pulse, err=1 sticky; the following bytes still use the correct round-1 key bytes.
- Gapped input: data_valid toggling 1/0 across a 16-byte round -> outputs identical to the back-to-back case; bc holds during gaps.
- rst asserted after key byte 7, and separately mid-round 3 -> next cycle all outputs at reset values, key_ready=0; a new key load followed by test 1 reproduces test 1's results exactly.
